// File: rtl/tcpc_pkg.sv
// Shared TCPC protocol-layer definitions: transmit state encodings,
// USB PD CRC-32 constants and the byte-wise reflected CRC update.
package tcpc_pkg;

  localparam int unsigned PD_MAX_BYTES = 30;

  localparam logic [31:0] PD_CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] PD_CRC_INIT = 32'hFFFFFFFF;

  // One-hot transmit byte engine states
  localparam logic [5:0] ST_IDLE     = 6'b000001;
  localparam logic [5:0] ST_FETCH    = 6'b000010;
  localparam logic [5:0] ST_LATCH    = 6'b000100;
  localparam logic [5:0] ST_SEND     = 6'b001000;
  localparam logic [5:0] ST_CRC_SEND = 6'b010000;
  localparam logic [5:0] ST_DONE     = 6'b100000;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

  // Reflected polynomial: the LSB-first update shifts right
  localparam logic [31:0] PD_CRC_POLY_REFL = bitrev32(PD_CRC_POLY);

  // One byte of reflected CRC-32, data consumed LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ PD_CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/pd_crc32.sv
// Running USB PD CRC-32 register; init reloads the seed, en folds in a byte.
module pd_crc32
  import tcpc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // CRC accumulator: seed on reset/init, update one byte per enable
  always_ff @(posedge clk) begin
    if (reset || init) crc <= PD_CRC_INIT;
    else if (en)       crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/tx_msg_builder.sv
// Transmit byte engine: reads header+data bytes from the TX buffer, streams
// them to the PHY over valid/ready, then appends the inverted CRC-32 LSB first.
module tx_msg_builder
  import tcpc_pkg::*;
#(
  parameter int unsigned MAX_BYTES = PD_MAX_BYTES,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pass_bytes,
  input  logic              tx_abort,
  input  logic [7:0]        byte_count,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [7:0]        buf_rd_data,
  output logic [7:0]        phy_data,
  output logic              phy_valid,
  input  logic              phy_ready,
  output logic              phy_sop,
  output logic              phy_eop,
  output logic              message_sent_to_phy,
  output logic              length_error,
  output logic              busy
);

  logic [5:0]        state;
  logic              pass_prev;
  logic [7:0]        count;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        crc_idx;
  logic [7:0]        data_reg;
  logic [31:0]       crc;
  logic [31:0]       crc_tx;

  logic start;
  logic in_range;
  logic last_byte;
  logic accept;

  assign start     = (state == ST_IDLE) && pass_bytes && !pass_prev;
  assign in_range  = (byte_count >= 8'd2) && (32'(byte_count) <= MAX_BYTES);
  assign last_byte = (8'(idx) + 8'd1) == count;
  assign accept    = phy_valid && phy_ready;
  assign crc_tx    = ~crc;

  pd_crc32 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (start && in_range),
    .en    (state == ST_LATCH),
    .data  (buf_rd_data),
    .crc   (crc)
  );

  // Edge detect on pass_bytes and the main sequencing FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      pass_prev    <= 1'b0;
      count        <= '0;
      idx          <= '0;
      crc_idx      <= '0;
      data_reg     <= '0;
      length_error <= 1'b0;
    end else begin
      pass_prev    <= pass_bytes;
      length_error <= 1'b0;
      if ((state != ST_IDLE) && tx_abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (in_range) begin
                count   <= byte_count;
                idx     <= '0;
                crc_idx <= '0;
                state   <= ST_FETCH;
              end else begin
                length_error <= 1'b1;
              end
            end
          end
          ST_FETCH: state <= ST_LATCH;
          ST_LATCH: begin
            data_reg <= buf_rd_data;
            state    <= ST_SEND;
          end
          ST_SEND: begin
            if (accept) begin
              idx   <= idx + ADDR_W'(1);
              state <= last_byte ? ST_CRC_SEND : ST_FETCH;
            end
          end
          ST_CRC_SEND: begin
            if (accept) begin
              crc_idx <= crc_idx + 2'd1;
              if (crc_idx == 2'd3) state <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // State-decoded handshake and buffer strobes
  always_comb begin
    buf_rd_en           = (state == ST_FETCH);
    buf_rd_addr         = (state == ST_FETCH) ? idx : '0;
    phy_valid           = (state == ST_SEND) || (state == ST_CRC_SEND);
    phy_sop             = (state == ST_SEND) && (idx == '0);
    phy_eop             = (state == ST_CRC_SEND) && (crc_idx == 2'd3);
    message_sent_to_phy = (state == ST_DONE);
    busy                = (state != ST_IDLE);
  end

  // Outgoing byte: buffered data, or the inverted CRC least-significant byte first
  always_comb begin
    phy_data = '0;
    if (state == ST_SEND) begin
      phy_data = data_reg;
    end else if (state == ST_CRC_SEND) begin
      case (crc_idx)
        2'd0:    phy_data = crc_tx[7:0];
        2'd1:    phy_data = crc_tx[15:8];
        2'd2:    phy_data = crc_tx[23:16];
        default: phy_data = crc_tx[31:24];
      endcase
    end
  end

endmodule

// File: tb/tb_tx_msg_builder.sv
// Self-checking bench for tx_msg_builder with a registered TX buffer model.
module tb_tx_msg_builder;

  logic       clk;
  logic       reset;
  logic       pass_bytes;
  logic       tx_abort;
  logic [7:0] byte_count;
  logic       buf_rd_en;
  logic [4:0] buf_rd_addr;
  logic [7:0] rd_data;
  logic [7:0] phy_data;
  logic       phy_valid;
  logic       phy_ready;
  logic       phy_sop;
  logic       phy_eop;
  logic       message_sent_to_phy;
  logic       length_error;
  logic       busy;

  logic [7:0] mem [0:31];

  int unsigned total  = 0;
  int unsigned passed = 0;

  tx_msg_builder #(.MAX_BYTES(30), .ADDR_W(5)) dut (
    .clk                 (clk),
    .reset               (reset),
    .pass_bytes          (pass_bytes),
    .tx_abort            (tx_abort),
    .byte_count          (byte_count),
    .buf_rd_en           (buf_rd_en),
    .buf_rd_addr         (buf_rd_addr),
    .buf_rd_data         (rd_data),
    .phy_data            (phy_data),
    .phy_valid           (phy_valid),
    .phy_ready           (phy_ready),
    .phy_sop             (phy_sop),
    .phy_eop             (phy_eop),
    .message_sent_to_phy (message_sent_to_phy),
    .length_error        (length_error),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TX buffer RAM: data valid the cycle after the read strobe
  always @(posedge clk) if (buf_rd_en) rd_data <= mem[buf_rd_addr];

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } acc_t;

  acc_t        acc_q[$];
  int unsigned msg_cnt = 0;
  int unsigned stall_viol = 0;
  int unsigned both_cnt = 0;
  logic        prev_stall = 1'b0;
  acc_t        prev_out;

  // Monitor: accepted bytes, frame pulses, stall stability
  always @(negedge clk) begin
    if (prev_stall && (!phy_valid || ({phy_data, phy_sop, phy_eop} != prev_out)))
      stall_viol <= stall_viol + 1;
    prev_stall <= phy_valid && !phy_ready && !tx_abort && !reset;
    prev_out   <= {phy_data, phy_sop, phy_eop};
    if (phy_valid && phy_ready) acc_q.push_back({phy_data, phy_sop, phy_eop});
    if (message_sent_to_phy) msg_cnt <= msg_cnt + 1;
    if (phy_sop && phy_eop) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {12'h000, buf_rd_en, buf_rd_addr, phy_data, phy_valid, phy_sop, phy_eop,
            message_sent_to_phy, length_error, busy};
  endfunction

  // Reference CRC: MSB-first CRC-32 on bit-reversed bytes, result reversed and inverted
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    logic [7:0]  b;
    logic [31:0] r;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) b[k] = mem[i][7 - k];
      c = c ^ {b, 24'h000000};
      for (int k = 0; k < 8; k++)
        c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    for (int k = 0; k < 32; k++) r[k] = c[31 - k];
    return ~r;
  endfunction

  // Compare the accepted bytes from acc_q[base] with buffer contents plus CRC
  task automatic check_frame(input string tag, input int base, input int n);
    logic [31:0] crc;
    logic [7:0]  eb;
    crc = ref_crc(n);
    check({tag, "_accepts"}, 32'(acc_q.size() - base), 32'(n + 4));
    if (acc_q.size() >= base + n + 4) begin
      for (int i = 0; i < n + 4; i++) begin
        if (i < n) eb = mem[i];
        else       eb = crc[8*(i-n) +: 8];
        check($sformatf("%s_byte%0d", tag, i), {22'h0, acc_q[base+i]},
              {22'h0, eb, i == 0, i == n + 3});
      end
    end
  endtask

  // Start a frame in cycle 0 and run until message_sent_to_phy (bounded)
  task automatic send_frame(input int n, input bit rnd, input bit hold, output int msg_cyc);
    msg_cyc = -1;
    next_cycle();
    byte_count = 8'(n);
    pass_bytes = 1'b1;
    phy_ready  = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      next_cycle();
      if (!hold) pass_bytes = 1'b0;
      phy_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (message_sent_to_phy) begin
        msg_cyc = c;
        break;
      end
    end
    check("frame_done", 32'(msg_cyc > 0), 32'd1);
    next_cycle();
    phy_ready = 1'b1;
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  typedef struct {
    logic [7:0] bc;
    logic       err;
  } len_t;

  exp_t nine[13];
  len_t lens[6];

  initial begin
    int          base;
    int          mc;
    int unsigned m0;
    bit          found;
    exp_t        e;

    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 5);
    for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);

    for (int k = 0; k < 9; k++) nine[k] = '{3 + 3*k, 8'(8'h31 + k), k == 0, 1'b0};
    nine[9]  = '{28, 8'h26, 1'b0, 1'b0};
    nine[10] = '{29, 8'h39, 1'b0, 1'b0};
    nine[11] = '{30, 8'hF4, 1'b0, 1'b0};
    nine[12] = '{31, 8'hCB, 1'b0, 1'b1};

    lens[0] = '{8'd0,   1'b1};
    lens[1] = '{8'd1,   1'b1};
    lens[2] = '{8'd31,  1'b1};
    lens[3] = '{8'd255, 1'b1};
    lens[4] = '{8'd2,   1'b0};
    lens[5] = '{8'd30,  1'b0};

    reset = 1'b1; pass_bytes = 1'b0; tx_abort = 1'b0; byte_count = 8'd0; phy_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_outputs", all_outs(), 32'h0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // 9-byte "123456789" frame, cycle-exact timing with ready high
    next_cycle();
    byte_count = 8'd9;
    pass_bytes = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      next_cycle();
      pass_bytes = 1'b0;
      byte_count = 8'd3;
      @(negedge clk);
      found = 1'b0;
      e = '{0, 8'h00, 1'b0, 1'b0};
      for (int j = 0; j < 13; j++) if (nine[j].cyc == c) begin found = 1'b1; e = nine[j]; end
      check($sformatf("crc9_valid_c%0d", c), {31'h0, phy_valid}, {31'h0, found});
      if (found)
        check($sformatf("crc9_byte_c%0d", c), {22'h0, phy_data, phy_sop, phy_eop},
              {22'h0, e.data, e.sop, e.eop});
      check($sformatf("crc9_msg_c%0d", c), {31'h0, message_sent_to_phy}, {31'h0, c == 32});
      check($sformatf("crc9_busy_c%0d", c), {31'h0, busy}, {31'h0, c <= 32});
    end

    // Length boundaries
    foreach (lens[i]) begin
      next_cycle();
      byte_count = lens[i].bc;
      pass_bytes = 1'b1;
      next_cycle();
      pass_bytes = 1'b0;
      @(negedge clk);
      check($sformatf("len%0d_err", lens[i].bc), {31'h0, length_error}, {31'h0, lens[i].err});
      check($sformatf("len%0d_busy", lens[i].bc), {31'h0, busy}, {31'h0, !lens[i].err});
      check($sformatf("len%0d_rd", lens[i].bc), {30'h0, buf_rd_en, phy_valid},
            lens[i].err ? 32'd0 : 32'd2);
      next_cycle();
      if (!lens[i].err) tx_abort = 1'b1;
      @(negedge clk);
      check($sformatf("len%0d_err_pulse", lens[i].bc), {31'h0, length_error}, 32'd0);
      next_cycle();
      tx_abort = 1'b0;
      @(negedge clk);
      check($sformatf("len%0d_idle", lens[i].bc), {29'h0, busy, buf_rd_en, phy_valid}, 32'd0);
    end

    // 2-byte frame with random ready stalls
    mem[0] = 8'h41;
    mem[1] = 8'h10;
    base = acc_q.size();
    m0 = msg_cnt;
    send_frame(2, 1'b1, 1'b0, mc);
    repeat (3) next_cycle();
    check_frame("stall2", base, 2);
    check("stall2_msgs", msg_cnt - m0, 32'd1);

    // Maximum length frame
    base = acc_q.size();
    send_frame(30, 1'b1, 1'b0, mc);
    repeat (2) next_cycle();
    check_frame("max30", base, 30);

    // Abort while the third byte is stalled, then a clean restart
    mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'hC3; mem[3] = 8'h3C; mem[4] = 8'h99;
    m0 = msg_cnt;
    next_cycle();
    byte_count = 8'd5;
    pass_bytes = 1'b1;
    phy_ready  = 1'b1;
    repeat (8) next_cycle();
    next_cycle();
    phy_ready = 1'b0;
    @(negedge clk);
    check("abort_third_valid", {23'h0, phy_valid, phy_data}, {23'h0, 1'b1, 8'hC3});
    next_cycle();
    tx_abort = 1'b1;
    @(negedge clk);
    check("abort_stall_hold", {23'h0, phy_valid, phy_data}, {23'h0, 1'b1, 8'hC3});
    next_cycle();
    tx_abort = 1'b0;
    phy_ready = 1'b1;
    @(negedge clk);
    check("abort_valid_drop", {30'h0, phy_valid, busy}, 32'd0);
    repeat (5) next_cycle();
    @(negedge clk);
    check("abort_no_restart", {31'h0, busy}, 32'd0);
    check("abort_no_msg", msg_cnt - m0, 32'd0);
    pass_bytes = 1'b0;
    next_cycle();
    base = acc_q.size();
    send_frame(5, 1'b0, 1'b0, mc);
    repeat (2) next_cycle();
    check_frame("restart5", base, 5);

    // pass_bytes held high for 100 cycles: one frame only
    for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
    m0 = msg_cnt;
    send_frame(9, 1'b0, 1'b1, mc);
    check("hold_msg_cycle", 32'(mc), 32'd32);
    repeat (66) next_cycle();
    @(negedge clk);
    check("hold_one_frame", msg_cnt - m0, 32'd1);
    check("hold_idle", {31'h0, busy}, 32'd0);
    pass_bytes = 1'b0;
    next_cycle();
    send_frame(9, 1'b0, 1'b0, mc);
    repeat (2) next_cycle();
    check("hold_second_frame", msg_cnt - m0, 32'd2);

    // Reset during CRC_SEND
    m0 = msg_cnt;
    next_cycle();
    byte_count = 8'd2;
    pass_bytes = 1'b1;
    phy_ready  = 1'b1;
    repeat (7) next_cycle();
    pass_bytes = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_crc_send", {30'h0, phy_valid, busy}, 32'd3);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", all_outs(), 32'h0);
    repeat (6) next_cycle();
    check("rst_no_msg", msg_cnt - m0, 32'd0);

    check("stall_stability", stall_viol, 32'd0);
    check("sop_eop_exclusive", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
